// File: rtl/lb_pulse_maker_mc_if.sv
// Bundle of per-channel inputs and outputs of the multi-channel pulse maker.
// The master side drives inputs and configuration, the slave side is the pulse maker.
interface lb_pulse_maker_mc_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned FILTER_W = 4
);
  logic [CHANNELS-1:0]   signal_in;
  logic [2*CHANNELS-1:0] edge_mode;
  logic [FILTER_W-1:0]   filter_thresh;
  logic [CHANNELS-1:0]   flag_clr;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   pulse;
  logic [CHANNELS-1:0]   event_flag;
  logic                  any_event;

  modport master (
    output signal_in, edge_mode, filter_thresh, flag_clr,
    input  level, pulse, event_flag, any_event
  );

  modport slave (
    input  signal_in, edge_mode, filter_thresh, flag_clr,
    output level, pulse, event_flag, any_event
  );
endinterface

// File: rtl/lb_pulse_maker_mc.sv
// Multi-channel edge-to-pulse generator: synchroniser, debounce filter,
// per-channel edge select, stretched pulse and sticky event flag per input.
module lb_pulse_maker_mc #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_W    = 4,
  parameter int unsigned PULSE_LEN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  lb_pulse_maker_mc_if.slave  bus
);

  localparam int unsigned PC_W = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN + 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  lvl_q, lvl_d;
  logic [CHANNELS-1:0]                  lvl_dly_q, lvl_dly_d;
  logic [CHANNELS-1:0][FILTER_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0][PC_W-1:0]        pc_q, pc_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic [CHANNELS-1:0]                  flag_q, flag_d;

  logic [CHANNELS-1:0] s_c;
  logic [CHANNELS-1:0] rise_c;
  logic [CHANNELS-1:0] fall_c;
  logic [CHANNELS-1:0] ev_c;

  assign s_c    = sync_q[SYNC_STAGES-1];
  assign rise_c = lvl_q & ~lvl_dly_q;
  assign fall_c = ~lvl_q & lvl_dly_q;

  // Synchroniser chain; stage 0 captures the asynchronous input
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.signal_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Edge qualification by per-channel mode bits: [0] rise, [1] fall
  always_comb begin
    ev_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      ev_c[c] = (bus.edge_mode[2*c] & rise_c[c]) | (bus.edge_mode[2*c+1] & fall_c[c]);
    end
  end

  always_comb begin
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    pulse_d   = pulse_q;
    flag_d    = flag_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      // Debounce: level follows s only after T+1 consecutive differing cycles
      if (s_c[c] == lvl_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] >= bus.filter_thresh) begin
        lvl_d[c] = s_c[c];
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + FILTER_W'(1);
      end

      // Retrigger reloads the counter so back-to-back events never gap
      if (ev_c[c]) begin
        pc_d[c] = PC_W'(PULSE_LEN);
      end else if (pc_q[c] != '0) begin
        pc_d[c] = pc_q[c] - PC_W'(1);
      end
      pulse_d[c] = (pc_d[c] != '0);

      // Set has priority over a coincident clear
      flag_d[c] = ev_c[c] | (flag_q[c] & ~bus.flag_clr[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      cnt_q     <= '0;
      pc_q      <= '0;
      pulse_q   <= '0;
      flag_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      pulse_q   <= pulse_d;
      flag_q    <= flag_d;
    end
  end

  assign bus.level      = lvl_q;
  assign bus.pulse      = pulse_q;
  assign bus.event_flag = flag_q;
  assign bus.any_event  = |flag_q;

endmodule

// File: tb/tb_lb_pulse_maker_mc.sv
// Bench for lb_pulse_maker_mc: two instances (pulse length 1 and 4) share the
// same stimulus and are checked against an event-history model every cycle.
module tb_lb_pulse_maker_mc;

  localparam int CH   = 8;
  localparam int S    = 2;
  localparam int L_A  = 1;
  localparam int L_B  = 4;
  localparam int HIST = 1024;

  logic        clk;
  logic        reset;
  logic [7:0]  sig;
  logic [15:0] mode;
  logic [3:0]  thr;
  logic [7:0]  clr;

  int vectors;
  int miscompares;

  lb_pulse_maker_mc_if #(.CHANNELS(CH), .FILTER_W(4)) bus_a ();
  lb_pulse_maker_mc_if #(.CHANNELS(CH), .FILTER_W(4)) bus_b ();

  assign bus_a.signal_in     = sig;
  assign bus_a.edge_mode     = mode;
  assign bus_a.filter_thresh = thr;
  assign bus_a.flag_clr      = clr;
  assign bus_b.signal_in     = sig;
  assign bus_b.edge_mode     = mode;
  assign bus_b.filter_thresh = thr;
  assign bus_b.flag_clr      = clr;

  lb_pulse_maker_mc #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_W(4), .PULSE_LEN(L_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  lb_pulse_maker_mc #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_W(4), .PULSE_LEN(L_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: histories indexed by edge number; pulses derived from last event edge
  int         n = 0;
  int         last_rst = -1000;
  logic [7:0] in_hist [0:HIST-1];
  logic [7:0] s_hist  [0:HIST-1];
  logic [7:0] lvl_m, flag_m, pulse_a_m, pulse_b_m;
  int         chg_edge [0:CH-1];
  logic       chg_dir  [0:CH-1];
  int         last_ev  [0:CH-1];
  bit         model_valid = 1'b0;

  always @(posedge clk) begin : model
    logic ev;
    logic differ;
    int   idx;
    if (!reset) begin
      last_rst  = n;
      lvl_m     = '0;
      flag_m    = '0;
      pulse_a_m = '0;
      pulse_b_m = '0;
      s_hist[n] = '0;
      in_hist[n] = '0;
      for (int c = 0; c < CH; c++) begin
        chg_edge[c] = -100;
        chg_dir[c]  = 1'b0;
        last_ev[c]  = -100;
      end
    end else begin
      in_hist[n] = sig;
      for (int c = 0; c < CH; c++) begin
        ev = (chg_edge[c] == n - 1) && (chg_dir[c] ? mode[2*c] : mode[2*c+1]);
        if (ev) last_ev[c] = n;
        pulse_a_m[c] = (n - last_ev[c]) < L_A;
        pulse_b_m[c] = (n - last_ev[c]) < L_B;
        flag_m[c]    = ev | (flag_m[c] & ~clr[c]);
        differ = 1'b1;
        for (int k = 0; k <= int'(thr); k++) begin
          idx = n - 1 - k;
          if (idx < 0 || idx < last_rst) differ = 1'b0;
          else if (s_hist[idx][c] == lvl_m[c]) differ = 1'b0;
        end
        if (differ) begin
          lvl_m[c]    = ~lvl_m[c];
          chg_edge[c] = n;
          chg_dir[c]  = lvl_m[c];
        end
      end
      s_hist[n] = (n - S + 1 <= last_rst) ? 8'h00 : in_hist[n - S + 1];
    end
    n++;
    model_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (model_valid) begin
      chk("level_a",  bus_a.level,      lvl_m);
      chk("level_b",  bus_b.level,      lvl_m);
      chk("pulse_a",  bus_a.pulse,      pulse_a_m);
      chk("pulse_b",  bus_b.pulse,      pulse_b_m);
      chk("flag_a",   bus_a.event_flag, flag_m);
      chk("flag_b",   bus_b.event_flag, flag_m);
      chk("any_a",    8'(bus_a.any_event), 8'(|flag_m));
      chk("any_b",    8'(bus_b.any_event), 8'(|flag_m));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    sig   = 8'h00;
    mode  = 16'h5555;
    thr   = 4'd0;
    clr   = 8'h00;
    step(3);
    chk("rst_level", bus_a.level, 8'h00);
    chk("rst_pulse", bus_a.pulse, 8'h00);
    chk("rst_flag",  bus_a.event_flag, 8'h00);
    chk("rst_any",   8'(bus_a.any_event), 8'h00);
    reset = 1'b1;
    step(3);

    // Single rising edge, default latency
    sig[0] = 1'b1;
    step(3);
    chk("t1_pulse_early", 8'(bus_a.pulse[0]), 8'h00);
    step(1);
    chk("t1_pulse",   8'(bus_a.pulse[0]), 8'h01);
    chk("t1_level",   8'(bus_a.level[0]), 8'h01);
    chk("t1_flag",    8'(bus_a.event_flag[0]), 8'h01);
    chk("t1_any",     8'(bus_a.any_event), 8'h01);
    chk("t1_pulse_b", 8'(bus_b.pulse[0]), 8'h01);
    step(1);
    chk("t1_pulse_end", 8'(bus_a.pulse[0]), 8'h00);
    chk("t1_pulse_b2",  8'(bus_b.pulse[0]), 8'h01);
    clr = 8'h01;
    step(1);
    clr = 8'h00;
    chk("t1_flag_clr", 8'(bus_a.event_flag[0]), 8'h00);
    chk("t1_any_clr",  8'(bus_a.any_event), 8'h00);
    step(4);

    // Debounce with T=3, channel 1 in both-edge mode
    thr  = 4'd3;
    mode = 16'h555D;
    step(2);
    sig[1] = 1'b1;
    step(3);
    sig[1] = 1'b0;
    step(8);
    chk("t2_glitch_level", 8'(bus_a.level[1]), 8'h00);
    chk("t2_glitch_flag",  8'(bus_a.event_flag[1]), 8'h00);
    sig[1] = 1'b1;
    step(5);
    sig[1] = 1'b0;
    step(1);
    chk("t2_level_up",    8'(bus_a.level[1]), 8'h01);
    chk("t2_pulse_wait",  8'(bus_a.pulse[1]), 8'h00);
    step(1);
    chk("t2_rise_pulse",  8'(bus_a.pulse[1]), 8'h01);
    step(4);
    chk("t2_level_down",  8'(bus_a.level[1]), 8'h00);
    chk("t2_fall_wait",   8'(bus_a.pulse[1]), 8'h00);
    step(1);
    chk("t2_fall_pulse",  8'(bus_a.pulse[1]), 8'h01);
    chk("t2_flag",        8'(bus_a.event_flag[1]), 8'h01);
    thr = 4'd0;
    clr = 8'hFF;
    step(1);
    clr = 8'h00;
    step(4);

    // Retrigger on the long-pulse instance: two rises two cycles apart
    sig[4] = 1'b1;
    step(1);
    sig[4] = 1'b0;
    step(1);
    sig[4] = 1'b1;
    step(2);
    chk("t3_b_first", 8'(bus_b.pulse[4]), 8'h01);
    step(1);
    chk("t3_a_gap",   8'(bus_a.pulse[4]), 8'h00);
    chk("t3_b_hold",  8'(bus_b.pulse[4]), 8'h01);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t3_b_cont", 8'(bus_b.pulse[4]), 8'h01);
    end
    step(1);
    chk("t3_b_end", 8'(bus_b.pulse[4]), 8'h00);

    // Set wins over coincident clear; lone clear next cycle
    clr = 8'hFF;
    step(1);
    clr = 8'h00;
    step(1);
    sig[2] = 1'b1;
    step(3);
    clr = 8'h04;
    step(1);
    chk("t4_set_wins", 8'(bus_a.event_flag[2]), 8'h01);
    chk("t4_pulse",    8'(bus_a.pulse[2]), 8'h01);
    step(1);
    chk("t4_cleared",  8'(bus_a.event_flag[2]), 8'h00);
    chk("t4_any_a",    8'(bus_a.any_event), 8'h00);
    chk("t4_any_b",    8'(bus_b.any_event), 8'h00);
    clr = 8'h00;
    step(2);

    // Channel 3 off: level tracks, no pulse or flag
    mode = 16'h551D;
    sig[3] = 1'b1;
    step(3);
    chk("t5_level_hi", 8'(bus_a.level[3]), 8'h01);
    sig[3] = 1'b0;
    step(3);
    chk("t5_level_lo", 8'(bus_a.level[3]), 8'h00);
    sig[3] = 1'b1;
    step(2);
    sig[3] = 1'b0;
    step(4);
    chk("t5_no_flag",  bus_a.event_flag, 8'h00);
    sig[0] = 1'b0;
    step(5);
    sig[0] = 1'b1;
    sig[7] = 1'b1;
    step(3);
    chk("t5_multi_wait", bus_a.pulse, 8'h00);
    step(1);
    chk("t5_multi",      bus_a.pulse, 8'h81);
    step(6);

    // Reset in the middle of a long pulse
    sig = 8'h41;
    step(4);
    sig[6] = 1'b0;
    step(1);
    sig[6] = 1'b1;
    step(4);
    chk("t6_b_pulse", 8'(bus_b.pulse[6]), 8'h01);
    reset = 1'b0;
    step(1);
    chk("t6_rst_pulse_a", bus_a.pulse, 8'h00);
    chk("t6_rst_pulse_b", bus_b.pulse, 8'h00);
    chk("t6_rst_level",   bus_a.level, 8'h00);
    chk("t6_rst_flag_b",  bus_b.event_flag, 8'h00);
    chk("t6_rst_any_b",   8'(bus_b.any_event), 8'h00);
    reset = 1'b1;
    step(3);
    chk("t6_rel_wait", bus_a.pulse, 8'h00);
    step(1);
    chk("t6_rel_pulse", bus_a.pulse, 8'h41);
    step(1);
    chk("t6_rel_end",   bus_a.pulse, 8'h00);
    step(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lb_pulse_maker_mc.md
Name: lb_pulse_maker_mc

Overview:
Multi-channel, parametrised edge-to-pulse generator. It is the successor of the single-channel rising-edge pulse maker. Each channel has:
- a synchroniser;
- a programmable glitch/debounce filter;
- a per-channel edge-mode select (rise/fall/both/off);
- a stretched output pulse of configurable length;
- a sticky event flag with clear.

It sits between asynchronous board inputs (buttons, external strobes) and the PicoBlaze I/O ports. Firmware polls the flags and clears them.

Parameters:
CHANNELS, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
FILTER_W, 4, width of debounce counter and threshold
PULSE_LEN, 1, output pulse length in clk cycles (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
signal_in  input  CHANNELS  asynchronous input levels
edge_mode  input  2*CHANNELS  per channel [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
filter_thresh  input  FILTER_W  debounce threshold T, shared by all channels
flag_clr  input  CHANNELS  per-channel sticky-flag clear, sampled each cycle
level  output  CHANNELS  filtered, synchronised level per channel
pulse  output  CHANNELS  registered pulse per channel
event_flag  output  CHANNELS  sticky event flag per channel
any_event  output  1  OR of event_flag (combinational)

Behaviour:
- Reset is synchronous: any clk edge with reset=0 clears all state. This covers sync flops, lvl, lvl_d, filter counter cnt, pulse counters, pulse and event_flag, all to 0.
- After reset, level=0. An input held high through reset therefore produces a rising event after the normal latency.
- Synchroniser: signal_in passes through a SYNC_STAGES flop chain; the chain output is s.
- Filter, per channel, each edge:
  - if s==lvl: cnt<=0;
  - else if cnt>=T: lvl<=s, cnt<=0;
  - else cnt<=cnt+1.
  - lvl changes only after s differs for T+1 consecutive cycles. T=0 gives 1-cycle filtering. Shorter glitches are discarded and cnt restarts.
  - level = lvl.
- Edge detection: lvl_d<=lvl each edge.
  - rise = lvl & ~lvl_d; fall = ~lvl & lvl_d.
  - ev = (mode[0]&rise) | (mode[1]&fall).
  - Mode 00 gives no events, but level still tracks.
- Pulse: per-channel down-counter pc.
  - If ev: pc<=PULSE_LEN; else if pc!=0: pc<=pc-1.
  - pulse is registered, high exactly when the next pc is nonzero. pulse therefore rises on the edge after ev and stays high for PULSE_LEN cycles.
  - A retrigger during a pulse reloads pc; pulse stays high continuously, with no gap.
- Latency: a signal_in change stable from edge 0 gives pulse=1 after edge SYNC_STAGES+T+2.
- event_flag:
  - ev sets the flag, flag_clr clears it.
  - If set and clear arrive in the same cycle, set wins.
  - The flag is updated on the same edge that pulse rises.
- edge_mode and filter_thresh are sampled every cycle; there is no shadowing.
  - A change takes effect on the next evaluation and does not truncate a running pulse.
  - Lowering T below the current cnt causes an update on the next differing cycle (cnt>=T).
- Channels are fully independent; simultaneous events on several channels are all captured.
- Reset asserted mid-pulse clears pulse on that edge.

Test Plan:
1. Defaults (S=2, T=0, L=1), mode 01, signal_in[0] 0->1 held. Required: pulse[0]=1 for exactly 1 cycle after edge 4, event_flag[0]=1, any_event=1, level[0]=1.
2. T=3, mode 11:
   - signal_in[1] 3-cycle high glitch: no pulse, level unchanged.
   - 5-cycle high: level rises after edge 2+4 and a pulse follows one edge later.
   - Return to 0: a fall pulse is produced.
3. PULSE_LEN=4, mode 01, two rising events 2 cycles apart (T=0). Required: pulse continuously high 6 cycles, never dropping between events.
4. Flag clear: set flag_clr[2] in the same cycle as a new event on channel 2. Required: flag stays 1. A clear on the next cycle alone gives 0, and any_event drops if no other flag is set.
5. Mode 00 on channel 3 with toggling input: level[3] follows (filtered), pulse[3] and event_flag[3] stay 0. Simultaneous rise on channels 0 and 7 (mode 01) pulses both on the same cycle.
6. Reset: assert reset=0 mid-pulse. Required: all outputs 0 on that edge. Release with signal_in[0]=1 gives one rising pulse at the normal latency.
